// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard sequencer: RV32 opcodes, PC-select
// encodings, FSM state type, default NOP encoding and a decode helper.
package hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  localparam logic [1:0] PC_SEL_PC4     = 2'd0;
  localparam logic [1:0] PC_SEL_HOLD    = 2'd1;
  localparam logic [1:0] PC_SEL_BR_TGT  = 2'd2;
  localparam logic [1:0] PC_SEL_JMP_TGT = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    StRun,
    StBrWait
  } state_e;

  // True for opcodes whose instructions write a destination register.
  function automatic logic opc_writes_rd(input logic [6:0] opc);
    return (opc == OPC_LUI)       || (opc == OPC_AUIPC)     ||
           (opc == OPC_JAL)       || (opc == OPC_JALR)      ||
           (opc == OPC_LOAD)      || (opc == OPC_ARI_ITYPE) ||
           (opc == OPC_ARI_RTYPE);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational instruction decode for the hazard sequencer.
// Ports:
//   i_ex_inst        instruction held in EX
//   i_if_inst        instruction currently out of the icache
//   o_ex_is_branch   EX holds a conditional branch
//   o_ex_is_jump     EX holds JAL or JALR
//   o_ex_writes_rd   EX writes a non-zero destination register
//   o_jalr_raw       IF holds a JALR whose rs1 is produced by the EX instruction
module hazard_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_ex_inst,
  input  logic [31:0] i_if_inst,
  output logic        o_ex_is_branch,
  output logic        o_ex_is_jump,
  output logic        o_ex_writes_rd,
  output logic        o_jalr_raw
);

  logic [6:0] w_ex_opc;
  logic [4:0] w_ex_rd;
  logic [6:0] w_if_opc;
  logic [4:0] w_if_rs1;
  logic       w_unused_bits;

  assign w_ex_opc = i_ex_inst[6:0];
  assign w_ex_rd  = i_ex_inst[11:7];
  assign w_if_opc = i_if_inst[6:0];
  assign w_if_rs1 = i_if_inst[19:15];

  // Remaining instruction fields are irrelevant to hazard detection.
  assign w_unused_bits = ^{i_ex_inst[31:12], i_if_inst[31:20], i_if_inst[14:7]};

  assign o_ex_is_branch = (w_ex_opc == OPC_BRANCH);
  assign o_ex_is_jump   = (w_ex_opc == OPC_JAL) || (w_ex_opc == OPC_JALR);
  assign o_ex_writes_rd = opc_writes_rd(w_ex_opc) && (w_ex_rd != 5'd0);
  assign o_jalr_raw     = (w_if_opc == OPC_JALR) && o_ex_writes_rd && (w_ex_rd == w_if_rs1);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 3-stage core (IF | EX | WB). Owns the EX
// instruction register, chooses the next-PC source, injects NOPs on killed IF
// slots and keeps a saturating count of those bubbles.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_stall          cache stall; freezes the controller
//   i_inst_if        instruction out of the icache
//   i_br_valid       branch result valid for the branch in EX
//   i_br_taken       branch outcome (meaningful with i_br_valid)
//   o_ex_inst        registered EX instruction
//   o_nop_sel        IF instruction killed this cycle
//   o_pc_sel         0 PC4, 1 HOLD, 2 BR_TGT, 3 JMP_TGT
//   o_ex_hold        EX keeps its instruction
//   o_nop_count      saturating count of killed IF slots
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT,
  parameter int unsigned BR_TIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic [31:0] i_inst_if,
  input  logic        i_br_valid,
  input  logic        i_br_taken,
  output logic [31:0] o_ex_inst,
  output logic        o_nop_sel,
  output logic [1:0]  o_pc_sel,
  output logic        o_ex_hold,
  output logic [31:0] o_nop_count
);

  localparam logic [7:0] TimeoutCnt = 8'(BR_TIMEOUT);

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_ex_inst;
  logic [31:0] r_nop_count;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_d;

  logic        w_ex_is_branch;
  logic        w_ex_is_jump;
  logic        w_ex_writes_rd;
  logic        w_jalr_raw;
  logic        w_nop_sel;
  logic [1:0]  w_pc_sel;
  logic        w_ex_hold;
  logic [1:0]  w_br_pc;

  hazard_decode u_decode (
    .i_ex_inst      (r_ex_inst),
    .i_if_inst      (i_inst_if),
    .o_ex_is_branch (w_ex_is_branch),
    .o_ex_is_jump   (w_ex_is_jump),
    .o_ex_writes_rd (w_ex_writes_rd),
    .o_jalr_raw     (w_jalr_raw)
  );

  assign w_br_pc = i_br_taken ? PC_SEL_BR_TGT : PC_SEL_PC4;

  always_comb begin
    w_nop_sel = 1'b0;
    w_pc_sel  = PC_SEL_PC4;
    w_ex_hold = 1'b0;
    w_state_d = r_state;
    w_wait_d  = r_wait_cnt;

    if (i_stall) begin
      w_pc_sel  = PC_SEL_HOLD;
      w_ex_hold = 1'b1;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_ex_is_branch) begin
            w_nop_sel = 1'b1;
            if (i_br_valid) begin
              w_pc_sel = w_br_pc;
            end else begin
              w_pc_sel  = PC_SEL_HOLD;
              w_ex_hold = 1'b1;
              w_state_d = StBrWait;
              w_wait_d  = 8'd1;
            end
          end else if (w_ex_is_jump) begin
            w_nop_sel = 1'b1;
            w_pc_sel  = PC_SEL_JMP_TGT;
          end else if (w_jalr_raw) begin
            // One bubble lets the producer reach WB; the JALR is refetched.
            w_nop_sel = 1'b1;
            w_pc_sel  = PC_SEL_HOLD;
          end
        end
        StBrWait: begin
          w_nop_sel = 1'b1;
          if (i_br_valid) begin
            w_pc_sel  = w_br_pc;
            w_state_d = StRun;
            w_wait_d  = 8'd0;
          end else if (r_wait_cnt == TimeoutCnt) begin
            // Branch unit never answered: fall through as not-taken.
            w_pc_sel  = PC_SEL_PC4;
            w_state_d = StRun;
            w_wait_d  = 8'd0;
          end else begin
            w_pc_sel  = PC_SEL_HOLD;
            w_ex_hold = 1'b1;
            w_wait_d  = r_wait_cnt + 8'd1;
          end
        end
        default: begin
          w_state_d = StRun;
          w_wait_d  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StRun;
      r_ex_inst   <= NOP_INST;
      r_nop_count <= 32'd0;
      r_wait_cnt  <= 8'd0;
    end else if (!i_stall) begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_d;
      if (!w_ex_hold) begin
        r_ex_inst <= w_nop_sel ? NOP_INST : i_inst_if;
      end
      if (w_nop_sel && (r_nop_count != 32'hFFFF_FFFF)) begin
        r_nop_count <= r_nop_count + 32'd1;
      end
    end
  end

  assign o_ex_inst   = r_ex_inst;
  assign o_nop_count = r_nop_count;
  assign o_nop_sel   = w_nop_sel;
  assign o_pc_sel    = w_pc_sel;
  assign o_ex_hold   = w_ex_hold;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] inst_if = 32'h0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] ex_inst;
  logic        nop_sel;
  logic [1:0]  pc_sel;
  logic        ex_hold;
  logic [31:0] nop_count;

  hazard_ctrl #(
    .NOP_INST   (NOP),
    .BR_TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_stall     (stall),
    .i_inst_if   (inst_if),
    .i_br_valid  (br_valid),
    .i_br_taken  (br_taken),
    .o_ex_inst   (ex_inst),
    .o_nop_sel   (nop_sel),
    .o_pc_sel    (pc_sel),
    .o_ex_hold   (ex_hold),
    .o_nop_count (nop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          chk_regs;
    bit          chk_comb;
    logic [31:0] ex;
    logic [31:0] cnt;
    logic        nop;
    logic [1:0]  pc;
    logic        hold;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  // Reference model state
  bit          m_init    = 0;
  bit          m_waiting = 0;
  int          m_wait    = 0;
  logic [31:0] m_ex      = NOP;
  logic [31:0] m_cnt     = 0;

  function automatic bit writes_rd(input logic [31:0] i);
    logic [6:0] o;
    o = i[6:0];
    if (i[11:7] == 5'd0) return 0;
    return o == 7'h37 || o == 7'h17 || o == 7'h6F || o == 7'h67 ||
           o == 7'h03 || o == 7'h13 || o == 7'h33;
  endfunction

  task automatic step(input bit r, input bit s, input logic [31:0] inst,
                      input bit bv, input bit bt, input bit preset);
    exp_t        e;
    logic        nop;
    logic [1:0]  pc;
    logic        hold;
    logic [6:0]  exo;
    @(negedge clk);
    if (preset) begin
      force dut.r_nop_count = 32'hFFFF_FFFE;
      release dut.r_nop_count;
      m_cnt = 32'hFFFF_FFFE;
    end
    rst = r; stall = s; inst_if = inst; br_valid = bv; br_taken = bt;

    nop = 0; pc = 0; hold = 0;
    exo = m_ex[6:0];
    if (s) begin
      pc = 1; hold = 1;
    end else if (m_waiting) begin
      nop = 1;
      if (bv || m_wait == TIMEOUT) pc = (bv && bt) ? 2'd2 : 2'd0;
      else begin pc = 1; hold = 1; end
    end else if (exo == 7'h63) begin
      nop = 1;
      if (bv) pc = bt ? 2'd2 : 2'd0;
      else begin pc = 1; hold = 1; end
    end else if (exo == 7'h6F || exo == 7'h67) begin
      nop = 1; pc = 3;
    end else if (inst[6:0] == 7'h67 && writes_rd(m_ex) && m_ex[11:7] == inst[19:15]) begin
      nop = 1; pc = 1;
    end

    e.id = step_id; e.chk_regs = m_init; e.chk_comb = m_init && !r;
    e.ex = m_ex; e.cnt = m_cnt; e.nop = nop; e.pc = pc; e.hold = hold;
    q.push_back(e);
    step_id++;

    if (r) begin
      m_init = 1; m_waiting = 0; m_wait = 0; m_ex = NOP; m_cnt = 0;
    end else if (!s) begin
      if (m_waiting) begin
        if (bv || m_wait == TIMEOUT) begin m_waiting = 0; m_wait = 0; end
        else m_wait++;
      end else if (exo == 7'h63 && !bv) begin
        m_waiting = 1; m_wait = 1;
      end
      if (!hold) m_ex = nop ? NOP : inst;
      if (nop && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic run(input logic [31:0] inst, input bit bv, input bit bt);
    step(0, 0, inst, bv, bt, 0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0]  opcs [10];
    opcs = '{7'h63, 7'h6F, 7'h67, 7'h67, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h33};
    i = $urandom;
    i[6:0]   = opcs[$urandom_range(0, 9)];
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  // Monitor: every cycle the DUT presents a full set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_regs) begin
          n_checks++;
          if (ex_inst !== e.ex) begin
            n_errors++;
            $display("FAIL ex_inst step %0d: got %h want %h", e.id, ex_inst, e.ex);
          end
          n_checks++;
          if (nop_count !== e.cnt) begin
            n_errors++;
            $display("FAIL nop_count step %0d: got %h want %h", e.id, nop_count, e.cnt);
          end
        end
        if (e.chk_comb) begin
          n_checks++;
          if ({nop_sel, pc_sel, ex_hold} !== {e.nop, e.pc, e.hold}) begin
            n_errors++;
            $display("FAIL ctrl step %0d: got nop=%b pc=%0d hold=%b want nop=%b pc=%0d hold=%b",
                     e.id, nop_sel, pc_sel, ex_hold, e.nop, e.pc, e.hold);
          end
        end
      end
    end
  end

  localparam logic [31:0] BEQ      = 32'h0020_8463;
  localparam logic [31:0] BNE      = 32'h0020_9463;
  localparam logic [31:0] ADDI_X5  = 32'h0040_0293;
  localparam logic [31:0] ADDI_X0  = 32'h0040_0013;
  localparam logic [31:0] JALR_X5  = 32'h0002_8067;
  localparam logic [31:0] JAL      = 32'h0000_006F;
  localparam logic [31:0] ADD      = 32'h0020_81B3;

  initial begin
    // Reset with stall asserted
    step(1, 1, ADD, 0, 0, 0);
    step(1, 1, ADD, 0, 0, 0);
    run(ADD, 0, 0);
    run(ADD, 0, 0);
    // Single-cycle taken branch
    run(BEQ, 0, 0);
    run(ADD, 1, 1);
    run(ADD, 0, 0);
    // Multi-cycle not-taken branch
    run(BNE, 0, 0);
    repeat (3) run(ADD, 0, 0);
    run(ADD, 1, 0);
    run(ADD, 0, 0);
    // Timeout
    run(BNE, 0, 0);
    repeat (10) run(ADD, 0, 0);
    // JALR RAW on x5, then rd=x0 producer
    run(ADDI_X5, 0, 0);
    run(JALR_X5, 0, 0);
    run(JALR_X5, 0, 0);
    run(ADD, 0, 0);
    run(ADDI_X0, 0, 0);
    run(JALR_X5, 0, 0);
    run(ADD, 0, 0);
    // Stall in BR_WAIT with br_valid pulsed
    run(BNE, 0, 0);
    run(ADD, 0, 0);
    step(0, 1, ADD, 0, 0, 0);
    step(0, 1, ADD, 1, 1, 0);
    step(0, 1, ADD, 0, 0, 0);
    step(0, 1, ADD, 0, 0, 0);
    run(ADD, 1, 1);
    run(ADD, 0, 0);
    // Saturation
    step(0, 1, ADD, 0, 0, 1);
    repeat (3) begin
      run(JAL, 0, 0);
      run(ADD, 0, 0);
    end
    run(ADD, 0, 0);
    // Reset while in BR_WAIT
    run(BNE, 0, 0);
    run(ADD, 0, 0);
    run(ADD, 0, 0);
    step(1, 0, ADD, 0, 0, 0);
    run(ADD, 0, 0);
    run(ADD, 0, 0);
    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), rand_inst(),
           ($urandom_range(0, 3) == 0), 1'($urandom), 0);
    end
    repeat (3) @(negedge clk);
    #4;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard sequencer for the 3-stage RISC-V core (IF | EX | WB). It owns the EX instruction register and decides, every cycle, whether the fetched instruction is replaced by a NOP, where the PC comes from, and whether EX holds. It handles branch resolution (which may be multi-cycle), JAL/JALR redirects, JALR-on-producer RAW bubbles, and instruction-cache stalls. It also keeps a saturating count of injected bubbles.

Parameters:
NOP_INST, 32'h0000_0013, encoding injected on kill (addi x0,x0,0)
BR_TIMEOUT, 8, max cycles in BR_WAIT before forced not-taken resolution; range 1..255

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
stall  in  1  icache/dcache stall; freezes the whole controller
inst_if  in  32  instruction currently out of the icache (IF stage)
br_valid  in  1  branch unit result valid for the branch in EX
br_taken  in  1  branch outcome; sampled only when br_valid=1
ex_inst  out  32  registered instruction in EX
nop_sel  out  1  1 = the IF instruction is killed (NOP_INST enters EX)
pc_sel  out  2  0 PC4, 1 HOLD, 2 BR_TGT, 3 JMP_TGT
ex_hold  out  1  1 = EX keeps its current instruction
nop_count  out  32  saturating count of killed IF slots

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high.
- Reset: state=RUN, ex_inst=NOP_INST, nop_count=0, wait counter=0. After reset the outputs are nop_sel=0, pc_sel=PC4, ex_hold=0. Reset overrides stall, and reset in any state, including BR_WAIT, returns the block to RUN.
- Decode: opcode=[6:0], rd=[11:7], rs1=[19:15], with constants from Opcode.vh.
- ex_writes_rd is true when the ex_inst opcode is one of LUI, AUIPC, JAL, JALR, LOAD, ARI_ITYPE, ARI_RTYPE, and rd != 0.
- EX register update, on a non-stalled cycle with ex_hold=0: ex_inst <= nop_sel ? NOP_INST : inst_if.
- Priority per cycle, highest first: rst, stall, EX branch, EX jump, JALR hazard, normal.
- stall=1:
  - All state, ex_inst and nop_count hold.
  - Outputs: pc_sel=HOLD, nop_sel=0, ex_hold=1.
  - br_valid is ignored while stalled.
- State RUN:
  - ex_inst is BRANCH:
    - br_valid=1: nop_sel=1, pc_sel = br_taken ? BR_TGT : PC4, ex_hold=0. Stay in RUN.
    - br_valid=0: nop_sel=1, pc_sel=HOLD, ex_hold=1. Go to BR_WAIT and set wait counter=1.
  - ex_inst is JAL or JALR: nop_sel=1, pc_sel=JMP_TGT.
  - inst_if is JALR, ex_writes_rd, and ex rd == inst_if rs1: nop_sel=1, pc_sel=HOLD, exactly one bubble. The JALR is refetched next cycle, when the producer is in WB.
  - Otherwise: nop_sel=0, pc_sel=PC4, ex_hold=0.
- State BR_WAIT (only one branch outstanding):
  - Every non-stalled cycle: nop_sel=1, ex_hold=1, pc_sel=HOLD.
  - br_valid=1: pc_sel = br_taken ? BR_TGT : PC4, ex_hold=0, go to RUN.
  - If wait counter == BR_TIMEOUT and br_valid=0: resolve as not-taken (pc_sel=PC4), ex_hold=0, go to RUN.
  - Otherwise increment the wait counter.
- nop_count: increments by 1 on every non-stalled, non-reset cycle with nop_sel=1, and saturates at 32'hFFFF_FFFF.
- Outputs nop_sel, pc_sel and ex_hold are combinational from state, ex_inst, inst_if, stall, br_valid and br_taken. Zero-latency redirect: the redirect happens in the same cycle the branch resolves.
- A JALR hazard is suppressed while an EX branch or jump is present; the killed slot covers it.

Decomposition:
- Shared header HazardCtrl.vh holds: PC_SEL_PC4/HOLD/BR_TGT/JMP_TGT (2-bit), STATE_RUN/STATE_BR_WAIT, and the NOP_INST default.
- Opcode.vh is reused for opcodes.
- One sub-module, hazard_decode: combinational. It produces is_branch/is_jump of ex_inst, ex_writes_rd, and jalr_raw.
- The FSM, EX register and counter stay in hazard_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles with stall=1 -> ex_inst=32'h00000013, nop_count=0, pc_sel=0, nop_sel=0, ex_hold=0.
- Single-cycle taken branch: ex_inst=BEQ x1,x2 (32'h00208463), br_valid=1, br_taken=1 -> pc_sel=2, nop_sel=1. Next cycle ex_inst=NOP, nop_count=1.
- Multi-cycle branch: BNE in EX, br_valid low 3 cycles then high with br_taken=0 -> 3 cycles of pc_sel=1, ex_hold=1, then pc_sel=0; nop_count += 4. Repeat with br_valid never asserted and BR_TIMEOUT=8 -> forced PC4 on the 8th BR_WAIT cycle.
- JALR RAW: ex_inst=addi x5,x0,4 (32'h00400293), inst_if=jalr x0,0(x5) (32'h00028067) -> nop_sel=1, pc_sel=1 for one cycle. The same case with rd=x0 -> no bubble.
- Stall mid-BR_WAIT: stall=1 for 4 cycles with br_valid=1 pulsed -> state, ex_inst and nop_count unchanged. Resolution occurs only after stall drops.
- Saturation and reset mid-wait: force nop_count near max (32'hFFFF_FFFE) plus 3 kills -> reads 32'hFFFF_FFFF. Assert rst in BR_WAIT -> RUN with ex_inst=NOP next cycle.
